// File: rtl/parking_door_actuator.sv
// Parking-gate motor sequencer: CLOSED -> OPENING -> OPEN (hold) -> CLOSING,
// timed by a tick prescaler, with reversal to OPENING on demand while closing.
module parking_door_actuator #(
  parameter int TICK_DIV     = 4,
  parameter int TRAVEL_TICKS = 3,
  parameter int HOLD_TICKS   = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       open_req,
  input  logic       car_sensor,
  output logic       door_open,
  output logic       motor_open,
  output logic       motor_close,
  output logic [1:0] door_state,
  output logic [7:0] door_pos,
  output logic       busy
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [1:0] ST_CLOSED  = 2'd0;
  localparam logic [1:0] ST_OPENING = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_CLOSING = 2'd3;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    TRAVEL    = 8'(TRAVEL_TICKS);
  localparam logic [7:0]    HOLD      = 8'(HOLD_TICKS);

  logic [PW-1:0] presc_q, presc_n;
  logic [7:0]    hold_q, hold_n;
  logic [7:0]    pos_n;
  logic [1:0]    state_n;
  logic          pulse_n;
  logic          tick;
  logic          reopen;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    tick    = (presc_q == TICK_LAST);
    reopen  = open_req | car_sensor;
    state_n = door_state;
    pos_n   = door_pos;
    hold_n  = hold_q;
    pulse_n = 1'b0;
    presc_n = tick ? '0 : presc_q + PW'(1);

    case (door_state)
      ST_CLOSED: begin
        if (open_req) begin
          state_n = ST_OPENING;
          pulse_n = 1'b1;
          presc_n = '0;
        end
      end
      ST_OPENING: begin
        // A reversal at full travel leaves nothing to open; settle straight into OPEN.
        if (door_pos >= TRAVEL) begin
          state_n = ST_OPEN;
          hold_n  = '0;
          presc_n = '0;
        end else if (tick) begin
          pos_n = door_pos + 8'd1;
          if (pos_n == TRAVEL) begin
            state_n = ST_OPEN;
            hold_n  = '0;
          end
        end
      end
      ST_OPEN: begin
        if (reopen) begin
          hold_n  = '0;
          presc_n = '0;
        end else if (tick) begin
          hold_n = hold_q + 8'd1;
          if (hold_n == HOLD) state_n = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
        // Reversal wins over a coincident tick: position is held.
        if (reopen) begin
          state_n = ST_OPENING;
          pulse_n = 1'b1;
          presc_n = '0;
        end else if (tick) begin
          pos_n = door_pos - 8'd1;
          if (pos_n == 8'd0) state_n = ST_CLOSED;
        end
      end
      default: begin
        state_n = ST_CLOSED;
        presc_n = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the comb block above uses blocking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      door_state  <= ST_CLOSED;
      door_pos    <= '0;
      hold_q      <= '0;
      presc_q     <= '0;
      door_open   <= 1'b0;
      motor_open  <= 1'b0;
      motor_close <= 1'b0;
      busy        <= 1'b0;
    end else begin
      door_state  <= state_n;
      door_pos    <= pos_n;
      hold_q      <= hold_n;
      presc_q     <= presc_n;
      door_open   <= pulse_n;
      motor_open  <= (state_n == ST_OPENING);
      motor_close <= (state_n == ST_CLOSING);
      busy        <= (state_n != ST_CLOSED);
    end
  end

endmodule
